// File: rtl/round_judge_if.sv
// Handshake and display bundle between the Memory Matrix board generator,
// the player input logic and the round judge.
interface round_judge_if;
    logic [7:0] board;
    logic       board_valid;
    logic       guess_valid;
    logic [2:0] guess_idx;
    logic       restart;
    logic [7:0] display;
    logic [7:0] hit_mask;
    logic [7:0] miss_mask;
    logic [2:0] mistakes;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       playing;
    logic       win;
    logic       lose;

    // Generator / player side: supplies board and guesses, observes the judge.
    modport master (
        output board, board_valid, guess_valid, guess_idx, restart,
        input  display, hit_mask, miss_mask, mistakes, hit_pulse, miss_pulse,
               playing, win, lose
    );

    // Judge side.
    modport slave (
        input  board, board_valid, guess_valid, guess_idx, restart,
        output display, hit_mask, miss_mask, mistakes, hit_pulse, miss_pulse,
               playing, win, lose
    );
endinterface

// File: rtl/round_judge.sv
// Round judge for the Memory Matrix game: captures the generated board,
// shows it for SHOW_CYCLES clocks, then scores player guesses until the
// whole pattern is found (WIN) or MAX_MISTAKES distinct wrong tiles are
// picked (LOSE). All outputs come from registers or registered state.
module round_judge #(
    parameter int SHOW_CYCLES  = 50000000,
    parameter int MAX_MISTAKES = 3,
    parameter int CNT_W        = 26
) (
    input  logic         clk,
    input  logic         reset,
    round_judge_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SHOW = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       MAX_MISS  = 3'(MAX_MISTAKES);

    state_t           state_r, state_s;
    logic [7:0]       target_r, target_s;
    logic [7:0]       hit_r, hit_s;
    logic [7:0]       miss_r, miss_s;
    logic [2:0]       mistakes_r, mistakes_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             hit_pulse_r, hit_pulse_s;
    logic             miss_pulse_r, miss_pulse_s;
    logic [7:0]       sel_s;
    logic [7:0]       display_s;

    // One-hot tile select from a 3-bit tile index.
    function automatic logic [7:0] tile_onehot(input logic [2:0] idx);
        tile_onehot = 8'd1 << idx;
    endfunction

    // Next-state and next-datapath logic; registers hold unless a phase acts.
    always_comb begin
        state_s      = state_r;
        target_s     = target_r;
        hit_s        = hit_r;
        miss_s       = miss_r;
        mistakes_s   = mistakes_r;
        cnt_s        = cnt_r;
        hit_pulse_s  = 1'b0;
        miss_pulse_s = 1'b0;
        sel_s        = tile_onehot(bus.guess_idx);

        case (state_r)
            ST_IDLE: begin
                if (bus.board_valid) begin
                    target_s   = bus.board;
                    hit_s      = 8'd0;
                    miss_s     = 8'd0;
                    mistakes_s = 3'd0;
                    cnt_s      = SHOW_LOAD;
                    state_s    = ST_SHOW;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_SHOW: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_PLAY;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end

            ST_PLAY: begin
                if (bus.guess_valid) begin
                    if ((target_r & sel_s) != 8'd0) begin
                        if ((hit_r & sel_s) == 8'd0) begin
                            hit_s       = hit_r | sel_s;
                            hit_pulse_s = 1'b1;
                        end else begin
                            hit_s       = hit_r;
                        end
                    end else begin
                        if ((miss_r & sel_s) == 8'd0) begin
                            miss_s       = miss_r | sel_s;
                            mistakes_s   = mistakes_r + 3'd1;
                            miss_pulse_s = 1'b1;
                        end else begin
                            miss_s       = miss_r;
                        end
                    end
                end else begin
                    hit_s = hit_r;
                end
                // Decide on the values this edge will commit, so an empty
                // board wins on its first PLAY cycle without any guess.
                if (hit_s == target_r) begin
                    state_s = ST_WIN;
                end else if (mistakes_s == MAX_MISS) begin
                    state_s = ST_LOSE;
                end else begin
                    state_s = ST_PLAY;
                end
            end

            ST_WIN, ST_LOSE: begin
                // restart outranks a simultaneous board_valid; the generator
                // re-issues the board once we are back in IDLE.
                if (bus.restart) begin
                    hit_s      = 8'd0;
                    miss_s     = 8'd0;
                    mistakes_s = 3'd0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s    = state_r;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                hit_s      = 8'd0;
                miss_s     = 8'd0;
                mistakes_s = 3'd0;
                cnt_s      = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            target_r     <= 8'd0;
            hit_r        <= 8'd0;
            miss_r       <= 8'd0;
            mistakes_r   <= 3'd0;
            cnt_r        <= {CNT_W{1'b0}};
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            target_r     <= target_s;
            hit_r        <= hit_s;
            miss_r       <= miss_s;
            mistakes_r   <= mistakes_s;
            cnt_r        <= cnt_s;
            hit_pulse_r  <= hit_pulse_s;
            miss_pulse_r <= miss_pulse_s;
        end
    end

    // Display mask decoded from registered state: pattern while showing and
    // after the round ends, found tiles while playing, dark when idle.
    always_comb begin
        display_s = 8'd0;
        case (state_r)
            ST_SHOW: display_s = target_r;
            ST_PLAY: display_s = hit_r;
            ST_WIN:  display_s = target_r;
            ST_LOSE: display_s = target_r;
            default: display_s = 8'd0;
        endcase
    end

    assign bus.display    = display_s;
    assign bus.hit_mask   = hit_r;
    assign bus.miss_mask  = miss_r;
    assign bus.mistakes   = mistakes_r;
    assign bus.hit_pulse  = hit_pulse_r;
    assign bus.miss_pulse = miss_pulse_r;
    assign bus.playing    = (state_r == ST_PLAY);
    assign bus.win        = (state_r == ST_WIN);
    assign bus.lose       = (state_r == ST_LOSE);

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: directed scenarios plus a randomized
// run, all compared against a behavioural model of the game rules.
module tb_round_judge;

    localparam int SHOW_CYCLES  = 4;
    localparam int MAX_MISTAKES = 3;

    localparam int P_IDLE = 0;
    localparam int P_SHOW = 1;
    localparam int P_PLAY = 2;
    localparam int P_WIN  = 3;
    localparam int P_LOSE = 4;

    logic clk;
    logic reset;
    round_judge_if bus ();

    round_judge #(
        .SHOW_CYCLES (SHOW_CYCLES),
        .MAX_MISTAKES(MAX_MISTAKES),
        .CNT_W       (26)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wire [31:0] obs = {bus.display, bus.hit_mask, bus.miss_mask, bus.mistakes,
                       bus.hit_pulse, bus.miss_pulse, bus.playing, bus.win, bus.lose};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase, pattern, sets of found/wrong tiles, show time left.
    int         m_phase = P_IDLE;
    logic [7:0] m_target = 8'd0;
    logic [7:0] m_hits   = 8'd0;
    logic [7:0] m_misses = 8'd0;
    int         m_left   = 0;
    logic       m_hp     = 1'b0;
    logic       m_mp     = 1'b0;

    function automatic logic [31:0] model_outputs();
        logic [7:0] disp;
        if (m_phase == P_PLAY)       disp = m_hits;
        else if (m_phase == P_IDLE)  disp = 8'd0;
        else                         disp = m_target;
        return {disp, m_hits, m_misses, 3'($countones(m_misses)), m_hp, m_mp,
                m_phase == P_PLAY, m_phase == P_WIN, m_phase == P_LOSE};
    endfunction

    task automatic model_step();
        logic [7:0] sel;
        sel  = 8'd1 << bus.guess_idx;
        m_hp = 1'b0;
        m_mp = 1'b0;
        if (!reset) begin
            m_phase = P_IDLE; m_target = 8'd0; m_hits = 8'd0; m_misses = 8'd0; m_left = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (bus.board_valid) begin
                    m_target = bus.board; m_hits = 8'd0; m_misses = 8'd0;
                    m_left = SHOW_CYCLES; m_phase = P_SHOW;
                end
                P_SHOW: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = P_PLAY;
                end
                P_PLAY: begin
                    if (bus.guess_valid) begin
                        if ((m_target & sel) != 8'd0) begin
                            if ((m_hits & sel) == 8'd0) begin m_hits |= sel; m_hp = 1'b1; end
                        end else if ((m_misses & sel) == 8'd0) begin
                            m_misses |= sel; m_mp = 1'b1;
                        end
                    end
                    if (m_hits == m_target) m_phase = P_WIN;
                    else if ($countones(m_misses) == MAX_MISTAKES) m_phase = P_LOSE;
                end
                default: if (bus.restart) begin
                    m_phase = P_IDLE; m_hits = 8'd0; m_misses = 8'd0;
                end
            endcase
        end
    endtask

    // Advance one clock: update model with the applied inputs, sample #1 later,
    // then drop the one-cycle pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        bus.board_valid = 1'b0;
        bus.guess_valid = 1'b0;
        bus.restart     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs !== 32'h0) $display("FAIL reset_state got=%h exp=%h", obs, 32'h0);
        else n_pass++;
        n_checks++;
        if (obs !== model_outputs()) $display("FAIL reset_model got=%h exp=%h", obs, model_outputs());
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_show_play_win();
        int         idx_list [4] = '{0, 2, 5, 7};
        logic [7:0] hm_list  [4] = '{8'h01, 8'h05, 8'h25, 8'hA5};
        bus.board = 8'hA5; bus.board_valid = 1'b1;
        tick();
        for (int i = 0; i < SHOW_CYCLES; i++) begin
            n_checks++;
            if (bus.display !== 8'hA5 || bus.playing !== 1'b0)
                $display("FAIL show_display cyc=%0d got=%h/%b exp=a5/0", i, bus.display, bus.playing);
            else n_pass++;
            if (i < SHOW_CYCLES - 1) tick();
        end
        tick();
        n_checks++;
        if (bus.playing !== 1'b1 || bus.display !== 8'h00)
            $display("FAIL play_entry got=%b/%h exp=1/00", bus.playing, bus.display);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus.guess_valid = 1'b1; bus.guess_idx = 3'(idx_list[i]);
            tick();
            n_checks++;
            if (bus.hit_mask !== hm_list[i] || bus.hit_pulse !== 1'b1)
                $display("FAIL hit_build i=%0d got=%h/%b exp=%h/1", i, bus.hit_mask, bus.hit_pulse, hm_list[i]);
            else n_pass++;
            n_checks++;
            if (obs !== model_outputs()) $display("FAIL hit_model i=%0d got=%h exp=%h", i, obs, model_outputs());
            else n_pass++;
        end
        n_checks++;
        if (bus.win !== 1'b1 || bus.display !== 8'hA5)
            $display("FAIL win_state got=%b/%h exp=1/a5", bus.win, bus.display);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.hit_pulse !== 1'b0 || bus.win !== 1'b1)
            $display("FAIL pulse_one_cycle got=%b/%b exp=0/1", bus.hit_pulse, bus.win);
        else n_pass++;
    endtask

    task automatic test_lose();
        int         g_list  [4] = '{1, 1, 2, 3};
        logic [2:0] mk_list [4] = '{3'd1, 3'd1, 3'd2, 3'd3};
        logic       mp_list [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bus.restart = 1'b1;
        tick();
        bus.board = 8'h01; bus.board_valid = 1'b1;
        tick();
        for (int i = 0; i < SHOW_CYCLES; i++) tick();
        for (int i = 0; i < 4; i++) begin
            bus.guess_valid = 1'b1; bus.guess_idx = 3'(g_list[i]);
            tick();
            n_checks++;
            if (bus.mistakes !== mk_list[i] || bus.miss_pulse !== mp_list[i])
                $display("FAIL miss_count i=%0d got=%0d/%b exp=%0d/%b", i, bus.mistakes, bus.miss_pulse, mk_list[i], mp_list[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.lose !== 1'b1 || bus.miss_mask !== 8'h0E || bus.display !== 8'h01 || bus.mistakes !== 3'd3)
            $display("FAIL lose_state got=%b/%h/%h/%0d exp=1/0e/01/3", bus.lose, bus.miss_mask, bus.display, bus.mistakes);
        else n_pass++;
        n_checks++;
        if (obs !== model_outputs()) $display("FAIL lose_model got=%h exp=%h", obs, model_outputs());
        else n_pass++;
        bus.guess_valid = 1'b1; bus.guess_idx = 3'd4;
        tick();
        n_checks++;
        if (bus.mistakes !== 3'd3 || bus.miss_pulse !== 1'b0)
            $display("FAIL lose_ignores_guess got=%0d/%b exp=3/0", bus.mistakes, bus.miss_pulse);
        else n_pass++;
    endtask

    task automatic test_empty_board();
        bus.restart = 1'b1;
        tick();
        bus.board = 8'h00; bus.board_valid = 1'b1;
        tick();
        for (int i = 0; i < SHOW_CYCLES; i++) tick();
        n_checks++;
        if (bus.playing !== 1'b1 || bus.win !== 1'b0)
            $display("FAIL empty_play got=%b/%b exp=1/0", bus.playing, bus.win);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.win !== 1'b1 || bus.playing !== 1'b0)
            $display("FAIL empty_win got=%b/%b exp=1/0", bus.win, bus.playing);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.restart = 1'b1;
        tick();
        bus.board = 8'h3C; bus.board_valid = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (obs !== 32'h0) $display("FAIL reset_mid_show got=%h exp=%h", obs, 32'h0);
        else n_pass++;
        bus.board = 8'h3C; bus.board_valid = 1'b1;
        tick();
        for (int i = 0; i < SHOW_CYCLES; i++) tick();
        bus.guess_valid = 1'b1; bus.guess_idx = 3'd0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (obs !== 32'h0) $display("FAIL reset_mid_play got=%h exp=%h", obs, 32'h0);
        else n_pass++;
        bus.board = 8'h81; bus.board_valid = 1'b1;
        tick();
        n_checks++;
        if (bus.display !== 8'h81 || obs !== model_outputs())
            $display("FAIL fresh_round got=%h exp=%h", obs, model_outputs());
        else n_pass++;
    endtask

    task automatic test_restart_with_board();
        for (int i = 0; i < SHOW_CYCLES; i++) tick();
        bus.guess_valid = 1'b1; bus.guess_idx = 3'd0;
        tick();
        bus.guess_valid = 1'b1; bus.guess_idx = 3'd7;
        tick();
        n_checks++;
        if (bus.win !== 1'b1) $display("FAIL reach_win got=%b exp=1", bus.win);
        else n_pass++;
        bus.restart = 1'b1; bus.board_valid = 1'b1; bus.board = 8'hFF;
        tick();
        n_checks++;
        if (obs !== 32'h0) $display("FAIL restart_wins got=%h exp=%h", obs, 32'h0);
        else n_pass++;
        tick();
        n_checks++;
        if (obs !== 32'h0) $display("FAIL board_dropped got=%h exp=%h", obs, 32'h0);
        else n_pass++;
        bus.board = 8'h5A; bus.board_valid = 1'b1;
        tick();
        n_checks++;
        if (bus.display !== 8'h5A || obs !== model_outputs())
            $display("FAIL show_after_restart got=%h exp=%h", obs, model_outputs());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset           = ($urandom_range(0, 99) != 0);
            bus.board_valid = ($urandom_range(0, 5) == 0);
            bus.board       = 8'($urandom);
            bus.guess_valid = ($urandom_range(0, 2) == 0);
            bus.guess_idx   = 3'($urandom_range(0, 7));
            bus.restart     = ($urandom_range(0, 11) == 0);
            tick();
            n_checks++;
            if (obs !== model_outputs())
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, model_outputs());
            else n_pass++;
        end
        reset = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        bus.board = 8'd0; bus.board_valid = 1'b0;
        bus.guess_valid = 1'b0; bus.guess_idx = 3'd0; bus.restart = 1'b0;
        #2;
        test_reset();
        test_show_play_win();
        test_lose();
        test_empty_board();
        test_reset_mid();
        test_restart_with_board();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Downstream consumer of the generated 8-tile board in the Memory Matrix game.
- Latches the board when the generator hands it over, shows the pattern for a fixed time, then hides it.
- Accepts one player tile guess at a time and tracks hits and misses.
- Declares win or lose and drives the 8-tile display mask for each phase.

Parameters:
SHOW_CYCLES, 50000000, clock cycles the pattern stays visible (1 s at 50 MHz); legal range >= 1
MAX_MISTAKES, 3, distinct wrong tiles that end the round in LOSE; legal range 1..7
CNT_W, 26, width of the show counter; must hold SHOW_CYCLES-1

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-low
board  input  8  generated pattern, bit i = tile i lit
board_valid  input  1  one-cycle pulse: board is stable and must be captured
guess_valid  input  1  one-cycle pulse: player selected a tile
guess_idx  input  3  index of selected tile
restart  input  1  one-cycle pulse: leave WIN/LOSE and return to IDLE
display  output  8  tiles to light
hit_mask  output  8  correctly found tiles
miss_mask  output  8  wrongly selected tiles
mistakes  output  3  count of distinct wrong tiles
hit_pulse  output  1  one-cycle: last accepted guess was a new hit
miss_pulse  output  1  one-cycle: last accepted guess was a new miss
playing  output  1  high in PLAY
win  output  1  high in WIN
lose  output  1  high in LOSE

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - target, hit_mask, miss_mask, mistakes, show counter and all pulses clear to 0.
  - Reset has priority in every state, including mid-SHOW and mid-PLAY.
- State encoding: IDLE, SHOW, PLAY, WIN, LOSE. All outputs are registered or decoded from registered state only.
- IDLE:
  - display=0.
  - On board_valid: target<=board, hit_mask<=0, miss_mask<=0, mistakes<=0, counter<=SHOW_CYCLES-1, next state SHOW.
  - Guesses and restart are ignored.
- SHOW:
  - display=target.
  - Counter decrements each cycle. When counter==0, next state is PLAY.
  - The pattern is visible for exactly SHOW_CYCLES cycles.
  - Guesses, board_valid and restart are ignored.
- PLAY:
  - display=hit_mask; playing=1.
  - On guess_valid with i=guess_idx:
    - target[i]=1 and hit_mask[i]=0: set hit_mask[i], hit_pulse=1 next cycle.
    - target[i]=1 and hit_mask[i]=1: repeat, no effect, no pulse.
    - target[i]=0 and miss_mask[i]=0: set miss_mask[i], mistakes+1, miss_pulse=1 next cycle.
    - target[i]=0 and miss_mask[i]=1: repeat, no effect, no penalty.
  - Transition checks use the post-update values on the same edge as the guess:
    - next hit_mask==target -> WIN.
    - next mistakes==MAX_MISTAKES -> LOSE.
    - Both cannot occur on one guess.
  - Latency: guess sampled at edge N; masks, counters, pulses and state are visible after edge N.
  - target==0: the first PLAY cycle moves to WIN with no guess needed.
  - board_valid and restart are ignored in PLAY.
- WIN:
  - win=1, display=target.
  - Masks and mistakes hold; guesses are ignored.
- LOSE:
  - lose=1, display=target (reveals the answer).
  - Masks and mistakes hold; guesses are ignored.
- WIN/LOSE exit: restart -> IDLE next edge; masks and mistakes clear on entry to IDLE.
- hit_pulse and miss_pulse are high for exactly one cycle and are otherwise 0.
- Simultaneous events:
  - board_valid and restart together in WIN/LOSE: restart wins and goes to IDLE; board_valid is dropped (the generator re-issues it).
  - guess_valid on the SHOW->PLAY transition cycle is ignored.
- mistakes never exceeds MAX_MISTAKES and never wraps.

Test Plan:
1. SHOW_CYCLES=4, board_valid with board=8'b1010_0101 -> display=A5 for exactly 4 cycles, then playing=1 and display=00.
2. In PLAY, guesses 0,2,5,7 -> hit_pulse on each, hit_mask builds 01,05,25,A5; win=1 the cycle after guess 7; display=A5.
3. MAX_MISTAKES=3, board=0x01, guesses 1,1,2,3 -> second guess 1 gives no miss_pulse and mistakes stays 1; lose=1 after guess 3, mistakes=3, miss_mask=0E, display=01.
4. board=0x00 -> after 4 SHOW cycles, one PLAY cycle, then win=1 with no guesses.
5. Assert reset=0 mid-SHOW and again mid-PLAY -> next cycle is IDLE with all outputs 0; a later board_valid starts a fresh round.
6. In WIN, pulse restart and board_valid together -> IDLE, masks 0, board not captured; a following board_valid enters SHOW.
